// File: rtl/sdram_read_pkg.sv
// rtl/sdram_read_pkg.sv - SDRAM command encodings, read-channel FSM states and sizing helpers.
package sdram_read_pkg;

    // {CS_n, RAS_n, CAS_n, WE_n}, shared with the write and refresh channels
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_PRECH = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;

    localparam int CNT_W   = 4;
    localparam int A10_BIT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACT,
        ST_TRCD,
        ST_RD,
        ST_PRECH,
        ST_TRP,
        ST_END
    } rd_state_t;

    // Address bus must carry the row, the column, and the A10 auto-precharge bit.
    function automatic int addr_width(input int row_w, input int col_w);
        int w;
        w = row_w;
        if (col_w + 1 > w) w = col_w + 1;
        if (A10_BIT + 1 > w) w = A10_BIT + 1;
        return w;
    endfunction

endpackage

// File: rtl/sdram_rd_lat_pipe.sv
// rtl/sdram_rd_lat_pipe.sv - CAS-latency valid shift register and DQ capture register.
module sdram_rd_lat_pipe #(
    parameter int DQ_W    = 16,
    parameter int CAS_LAT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [DQ_W-1:0] dq,
    output logic [DQ_W-1:0] rd_data,
    output logic            rd_data_vld
);

    logic [CAS_LAT-1:0] vld_sr;

    // Runs regardless of the FSM so bursts issued before PRECH still drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr      <= '0;
            rd_data_vld <= 1'b0;
            rd_data     <= '0;
        end else begin
            vld_sr      <= {vld_sr[CAS_LAT-2:0], load};
            rd_data_vld <= vld_sr[CAS_LAT-1];
            if (vld_sr[CAS_LAT-1]) begin
                rd_data <= dq;
            end
        end
    end

endmodule

// File: rtl/sdram_read.sv
// rtl/sdram_read.sv - SDRAM read channel: ACT, seamless BL4 READs over a row, PRECH,
// with refresh yield at burst boundaries and resume at the interrupted column.
module sdram_read
    import sdram_read_pkg::*;
#(
    parameter int ROW_W   = 13,
    parameter int COL_W   = 9,
    parameter int DQ_W    = 16,
    parameter int CAS_LAT = 3,
    parameter int T_RCD   = 2,
    parameter int T_RP    = 2,
    localparam int ADDR_W = addr_width(ROW_W, COL_W)
) (
    input  logic              sysclk_100M,
    input  logic              rst_n,
    input  logic              read_trig,
    output logic              arbit_read_req,
    input  logic              arbit_read_ack,
    input  logic              refresh_req,
    output logic              arbit_prech_end,
    output logic              read_end,
    output logic [3:0]        cmd_reg,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [1:0]        sdram_bank_addr,
    input  logic [DQ_W-1:0]   sdram_dq_in,
    output logic [DQ_W-1:0]   rd_data,
    output logic              rd_data_vld
);

    localparam logic [ADDR_W-1:0] ADDR_A10  = ADDR_W'(1) << A10_BIT;
    localparam logic [CNT_W-1:0]  TRCD_LAST = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0]  TRP_LAST  = CNT_W'(T_RP - 2);
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(3);

    rd_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic             row_done, row_done_nxt;
    logic             rd_load;

    assign sdram_bank_addr = 2'b00;

    always_ff @(posedge sysclk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            row      <= '0;
            col      <= '0;
            row_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            row_done <= row_done_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        row_nxt         = row;
        col_nxt         = col;
        row_done_nxt    = row_done;
        cmd_reg         = CMD_NOP;
        sdram_addr      = '0;
        arbit_read_req  = 1'b0;
        arbit_prech_end = 1'b0;
        read_end        = 1'b0;
        rd_load         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (read_trig) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                arbit_read_req = 1'b1;
                if (arbit_read_ack) state_nxt = ST_ACT;
            end
            ST_ACT: begin
                cmd_reg    = CMD_ACT;
                sdram_addr = ADDR_W'(row);
                cnt_nxt    = '0;
                state_nxt  = ST_TRCD;
            end
            ST_TRCD: begin
                if (cnt == TRCD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_RD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_RD: begin
                rd_load = 1'b1;
                if (cnt == '0) begin
                    cmd_reg    = CMD_READ;
                    sdram_addr = ADDR_W'(col);
                    col_nxt    = col + COL_W'(4);
                end
                // col was advanced at the slot's READ, so zero here means the row wrapped
                if (cnt == SLOT_LAST) begin
                    cnt_nxt = '0;
                    if (col == '0) begin
                        row_done_nxt = 1'b1;
                        state_nxt    = ST_PRECH;
                    end else if (refresh_req || !arbit_read_ack) begin
                        row_done_nxt = 1'b0;
                        state_nxt    = ST_PRECH;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_PRECH: begin
                cmd_reg    = CMD_PRECH;
                sdram_addr = ADDR_A10;
                cnt_nxt    = '0;
                state_nxt  = ST_TRP;
            end
            ST_TRP: begin
                if (cnt == TRP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_END;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_END: begin
                if (row_done) begin
                    read_end = 1'b1;
                    row_nxt  = row + 1'b1;
                    col_nxt  = '0;
                end else begin
                    arbit_prech_end = 1'b1;
                end
                row_done_nxt = 1'b0;
                state_nxt    = (row_done || !read_trig) ? ST_IDLE : ST_REQ;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    sdram_rd_lat_pipe #(
        .DQ_W    (DQ_W),
        .CAS_LAT (CAS_LAT)
    ) u_lat_pipe (
        .clk         (sysclk_100M),
        .rst_n       (rst_n),
        .load        (rd_load),
        .dq          (sdram_dq_in),
        .rd_data     (rd_data),
        .rd_data_vld (rd_data_vld)
    );

endmodule
